// File: rtl/dfe_train_ctrl_pkg.sv
// Shared definitions for the DFE training controller: FSM state codes,
// PN7 tap positions and the error-magnitude helper.
package dfe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_TRAIN = 3'd2,
    ST_TRACK = 3'd3,
    ST_FAIL  = 3'd4
  } dfe_state_e;

  // x^7 + x^6 + 1: feedback is the XOR of the two top register bits
  localparam int PN7_TAP_HI = 6;
  localparam int PN7_TAP_LO = 5;

  localparam int ERR_MAG_W = 16;

  // Two's-complement magnitude; the most negative code saturates to max positive
  function automatic logic [ERR_MAG_W-1:0] err_abs(input logic [ERR_MAG_W-1:0] e);
    logic [ERR_MAG_W-1:0] mag;
    if (e == 16'h8000) begin
      mag = 16'h7FFF;
    end else if (e[ERR_MAG_W-1]) begin
      mag = ~e + 16'd1;
    end else begin
      mag = e;
    end
    return mag;
  endfunction

endpackage

// File: rtl/dfe_train_ctrl_if.sv
// Control/status bundle between the training controller and its environment.
// master: the side that drives start/abort and the equalizer observations.
// slave:  the controller itself.
interface dfe_train_ctrl_if;
  logic        start;
  logic        abort;
  logic        sym_valid;
  logic        dec_bit;
  logic [15:0] err;
  logic        dfe_rst_n;
  logic        adapt_en;
  logic        train_mode;
  logic        train_bit;
  logic        locked;
  logic        fail;
  logic [2:0]  state;

  modport master (
    output start, abort, sym_valid, dec_bit, err,
    input  dfe_rst_n, adapt_en, train_mode, train_bit, locked, fail, state
  );

  modport slave (
    input  start, abort, sym_valid, dec_bit, err,
    output dfe_rst_n, adapt_en, train_mode, train_bit, locked, fail, state
  );
endinterface

// File: rtl/dfe_train_ctrl_pn7_gen.sv
// PN7 training-reference generator (x^7 + x^6 + 1). bit_out is the current
// top register bit, so it labels the symbol presented in the same cycle as adv.
module dfe_pn7_gen
  import dfe_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [6:0] seed,
  input  logic       adv,
  output logic       bit_out
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;

  // Next LFSR value: reload has priority over advancing
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = seed;
    end else if (adv) begin
      lfsr_d = {lfsr_q[5:0], lfsr_q[PN7_TAP_HI] ^ lfsr_q[PN7_TAP_LO]};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR register, reset to the seed so train_bit is defined out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_out = lfsr_q[PN7_TAP_HI];

endmodule

// File: rtl/dfe_train_ctrl.sv
// Lifecycle sequencer for the 2F/2B decision-feedback equalizer:
// clear -> PN7 training -> decision-directed tracking with windowed error
// monitoring that declares lock or failure.
module dfe_train_ctrl
  import dfe_ctrl_pkg::*;
#(
  parameter int unsigned TRAIN_LEN = 256,
  parameter int unsigned WIN_LEN   = 64,
  parameter logic [15:0] ERR_THR   = 16'h2000,
  parameter int unsigned ERR_MAX   = 4,
  parameter int unsigned BAD_MAX   = 2,
  parameter int unsigned CLR_CYC   = 4,
  parameter logic [6:0]  PN_SEED   = 7'h7F
)(
  input  logic            clk,
  input  logic            reset,
  dfe_train_ctrl_if.slave bus
);

  localparam logic [15:0] TRN_LAST = 16'(TRAIN_LEN - 1);
  localparam logic [7:0]  WIN_LAST = 8'(WIN_LEN - 1);
  localparam logic [3:0]  CLR_LAST = 4'(CLR_CYC - 1);
  localparam logic [7:0]  ERR_LIM  = 8'(ERR_MAX);
  localparam logic [7:0]  BAD_LIM  = 8'(BAD_MAX);

  dfe_state_e  state_q, state_d;
  logic [3:0]  clr_cnt_q, clr_cnt_d;
  logic [15:0] trn_cnt_q, trn_cnt_d;
  logic [7:0]  win_cnt_q, win_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [7:0]  bad_cnt_q, bad_cnt_d;
  logic        dfe_rst_n_q, dfe_rst_n_d;
  logic        adapt_en_q, adapt_en_d;
  logic        train_mode_q, train_mode_d;
  logic        locked_q, locked_d;
  logic        fail_q, fail_d;

  logic [ERR_MAG_W-1:0] err_mag_s;
  logic                 err_hit_s;
  logic [7:0]           err_tot_s;
  logic [7:0]           bad_inc_s;
  logic                 pn_load_s;
  logic                 pn_adv_s;

  // Error event for the current symbol and the window total including it
  assign err_mag_s = err_abs(bus.err);
  assign err_hit_s = (err_mag_s > ERR_THR);
  assign err_tot_s = (err_hit_s && (err_cnt_q != 8'hFF)) ? (err_cnt_q + 8'd1) : err_cnt_q;
  assign bad_inc_s = (bad_cnt_q != 8'hFF) ? (bad_cnt_q + 8'd1) : bad_cnt_q;

  // PN7 is reseeded throughout CLEAR and steps once per training symbol
  assign pn_load_s = (state_q == ST_CLEAR);
  assign pn_adv_s  = (state_q == ST_TRAIN) && bus.sym_valid;

  dfe_pn7_gen u_pn7 (
    .clk     (clk),
    .reset   (reset),
    .load    (pn_load_s),
    .seed    (PN_SEED),
    .adv     (pn_adv_s),
    .bit_out (bus.train_bit)
  );

  // Next state, counters and status flags; outputs decoded from the next state
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = 4'd0;
    trn_cnt_d = trn_cnt_q;
    win_cnt_d = win_cnt_q;
    err_cnt_d = err_cnt_q;
    bad_cnt_d = bad_cnt_q;
    locked_d  = locked_q;
    fail_d    = fail_q;

    case (state_q)
      ST_IDLE: begin
        trn_cnt_d = 16'd0;
        win_cnt_d = 8'd0;
        err_cnt_d = 8'd0;
        bad_cnt_d = 8'd0;
        locked_d  = 1'b0;
        if (bus.start) begin
          state_d = ST_CLEAR;
          fail_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        trn_cnt_d = 16'd0;
        win_cnt_d = 8'd0;
        err_cnt_d = 8'd0;
        bad_cnt_d = 8'd0;
        locked_d  = 1'b0;
        if (clr_cnt_q >= CLR_LAST) begin
          state_d = ST_TRAIN;
        end else begin
          clr_cnt_d = clr_cnt_q + 4'd1;
        end
      end
      ST_TRAIN: begin
        locked_d = 1'b0;
        if (bus.sym_valid) begin
          if (trn_cnt_q >= TRN_LAST) begin
            trn_cnt_d = 16'd0;
            state_d   = ST_TRACK;
          end else begin
            trn_cnt_d = trn_cnt_q + 16'd1;
          end
        end else begin
          trn_cnt_d = trn_cnt_q;
        end
      end
      ST_TRACK: begin
        if (bus.sym_valid) begin
          if (win_cnt_q >= WIN_LAST) begin
            // Window closes on this symbol, its own error already folded in
            win_cnt_d = 8'd0;
            err_cnt_d = 8'd0;
            if (err_tot_s <= ERR_LIM) begin
              locked_d  = 1'b1;
              bad_cnt_d = 8'd0;
            end else begin
              locked_d  = 1'b0;
              bad_cnt_d = bad_inc_s;
              if (bad_inc_s >= BAD_LIM) begin
                state_d = ST_FAIL;
              end else begin
                state_d = ST_TRACK;
              end
            end
          end else begin
            win_cnt_d = win_cnt_q + 8'd1;
            err_cnt_d = err_tot_s;
          end
        end else begin
          win_cnt_d = win_cnt_q;
        end
      end
      ST_FAIL: begin
        trn_cnt_d = 16'd0;
        win_cnt_d = 8'd0;
        err_cnt_d = 8'd0;
        bad_cnt_d = 8'd0;
        locked_d  = 1'b0;
        if (bus.start) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_FAIL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides everything, including a simultaneous start; fail is kept
    if (bus.abort) begin
      state_d   = ST_IDLE;
      clr_cnt_d = 4'd0;
      trn_cnt_d = 16'd0;
      win_cnt_d = 8'd0;
      err_cnt_d = 8'd0;
      bad_cnt_d = 8'd0;
      locked_d  = 1'b0;
      fail_d    = fail_q;
    end else begin
      clr_cnt_d = clr_cnt_d;
    end

    if (state_d == ST_FAIL) begin
      fail_d   = 1'b1;
      locked_d = 1'b0;
    end else begin
      fail_d = fail_d;
    end

    dfe_rst_n_d  = (state_d != ST_CLEAR);
    adapt_en_d   = (state_d == ST_TRAIN) || (state_d == ST_TRACK);
    train_mode_d = (state_d == ST_TRAIN);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      clr_cnt_q    <= 4'd0;
      trn_cnt_q    <= 16'd0;
      win_cnt_q    <= 8'd0;
      err_cnt_q    <= 8'd0;
      bad_cnt_q    <= 8'd0;
      dfe_rst_n_q  <= 1'b1;
      adapt_en_q   <= 1'b0;
      train_mode_q <= 1'b0;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      trn_cnt_q    <= trn_cnt_d;
      win_cnt_q    <= win_cnt_d;
      err_cnt_q    <= err_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      dfe_rst_n_q  <= dfe_rst_n_d;
      adapt_en_q   <= adapt_en_d;
      train_mode_q <= train_mode_d;
      locked_q     <= locked_d;
      fail_q       <= fail_d;
    end
  end

  assign bus.dfe_rst_n  = dfe_rst_n_q;
  assign bus.adapt_en   = adapt_en_q;
  assign bus.train_mode = train_mode_q;
  assign bus.locked     = locked_q;
  assign bus.fail       = fail_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_dfe_train_ctrl.sv
// Self-checking bench for dfe_train_ctrl (TRAIN_LEN=16, WIN_LEN=8, CLR_CYC=4).
module tb_dfe_train_ctrl;
  import dfe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dfe_train_ctrl_if bus ();

  dfe_train_ctrl #(
    .TRAIN_LEN (16),
    .WIN_LEN   (8),
    .ERR_THR   (16'h2000),
    .ERR_MAX   (4),
    .BAD_MAX   (2),
    .CLR_CYC   (4),
    .PN_SEED   (7'h7F)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       lk;
    logic       fl;
    logic       ad;
    logic [2:0] st;
  } win_exp_t;

  int total = 0;
  int bad   = 0;

  logic       tbit_q[$];
  win_exp_t   win_q[$];
  logic [6:0] m_lfsr;
  logic       m_locked;
  int         m_bad;
  logic [2:0] m_state;
  logic [7:0] pn_tab;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mag(input logic [15:0] e);
    if (e == 16'h8000) return 16'h7FFF;
    if (e[15]) return 16'h0000 - e;
    return e;
  endfunction

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Count cycles with dfe_rst_n low, bounded
  task automatic wait_clear();
    int n = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.dfe_rst_n !== 1'b0) break;
      n++;
      tick();
    end
    chk_val("clr_len", n, 4);
    chk_val("train_adapt", {31'd0, bus.adapt_en}, 1);
    chk_val("train_mode", {31'd0, bus.train_mode}, 1);
    chk_val("train_state", {29'd0, bus.state}, 2);
  endtask

  task automatic train_syms(input int n, input bit use_tab, input bit try_start);
    for (int i = 0; i < n; i++) begin
      bus.sym_valid = 1'b1;
      tbit_q.push_back(m_lfsr[6]);
      if (try_start && i == 5) bus.start = 1'b1;
      chk_val("train_bit", {31'd0, bus.train_bit}, {31'd0, tbit_q.pop_front()});
      if (use_tab && i < 8) chk_val("pn_first8", {31'd0, bus.train_bit}, {31'd0, pn_tab[7-i]});
      tick();
      bus.start = 1'b0;
      m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
      if (try_start && i == 5) chk_val("start_ign", {29'd0, bus.state}, 2);
    end
    bus.sym_valid = 1'b0;
  endtask

  task automatic window(input logic [7:0][15:0] errs, input bit gaps);
    int nerr = 0;
    win_exp_t e;
    for (int i = 0; i < 8; i++) begin
      bus.sym_valid = 1'b1;
      bus.err = errs[i];
      if (mag(errs[i]) > 16'h2000) nerr++;
      tick();
      if (gaps) begin
        bus.sym_valid = 1'b0;
        bus.err = 16'h8000;
        tick();
        tick();
        if (i == 6) chk_val("mid_win_lock", {31'd0, bus.locked}, {31'd0, m_locked});
      end
    end
    bus.sym_valid = 1'b0;
    bus.err = 16'h0000;
    if (nerr <= 4) begin
      m_locked = 1'b1;
      m_bad = 0;
    end else begin
      m_locked = 1'b0;
      m_bad++;
      if (m_bad >= 2) m_state = 3'd4;
    end
    e.lk = m_locked;
    e.fl = (m_state == 3'd4);
    e.ad = (m_state == 3'd3);
    e.st = m_state;
    win_q.push_back(e);
    e = win_q.pop_front();
    chk_val("win_locked", {31'd0, bus.locked}, {31'd0, e.lk});
    chk_val("win_fail", {31'd0, bus.fail}, {31'd0, e.fl});
    chk_val("win_adapt", {31'd0, bus.adapt_en}, {31'd0, e.ad});
    chk_val("win_state", {29'd0, bus.state}, {29'd0, e.st});
  endtask

  initial begin
    logic [7:0][15:0] w_ok;
    logic [7:0][15:0] w_edge;
    logic [7:0][15:0] w_bad;
    pn_tab = 8'b1111_1110;
    w_ok   = {8{16'h1000}};
    // element 0 is the first symbol sent: 2001, DFFF, 8000, 8000 are events; 2000, E000 are not
    w_edge = {16'h0000, 16'hE000, 16'h2000, 16'h2000, 16'h8000, 16'h8000, 16'hDFFF, 16'h2001};
    w_bad  = {16'h1000, 16'h1000, 16'h1000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.sym_valid = 1'b0;
    bus.dec_bit = 1'b0;
    bus.err = 16'h0000;
    tick(); tick(); tick();
    reset = 1'b0;
    chk_val("rst_state", {29'd0, bus.state}, 0);
    chk_val("rst_dfe_rst_n", {31'd0, bus.dfe_rst_n}, 1);
    chk_val("rst_adapt", {31'd0, bus.adapt_en}, 0);
    chk_val("rst_tmode", {31'd0, bus.train_mode}, 0);
    chk_val("rst_locked", {31'd0, bus.locked}, 0);
    chk_val("rst_fail", {31'd0, bus.fail}, 0);
    chk_val("rst_tbit", {31'd0, bus.train_bit}, 1);

    // Sequence 1: clear, train 16, track into FAIL
    pulse_start();
    m_lfsr = 7'h7F;
    wait_clear();
    train_syms(16, 1'b1, 1'b1);
    chk_val("handover_tmode", {31'd0, bus.train_mode}, 0);
    chk_val("handover_locked", {31'd0, bus.locked}, 0);
    chk_val("handover_state", {29'd0, bus.state}, 3);
    m_locked = 1'b0;
    m_bad = 0;
    m_state = 3'd3;
    window(w_ok, 1'b1);
    window(w_edge, 1'b0);
    window(w_bad, 1'b0);
    window(w_bad, 1'b0);

    // FAIL ignores symbols; abort keeps fail
    bus.sym_valid = 1'b1;
    tick(); tick();
    bus.sym_valid = 1'b0;
    chk_val("fail_hold", {29'd0, bus.state}, 4);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk_val("abort_state", {29'd0, bus.state}, 0);
    chk_val("abort_fail_kept", {31'd0, bus.fail}, 1);

    // Restart from IDLE clears fail
    pulse_start();
    chk_val("restart_state", {29'd0, bus.state}, 1);
    chk_val("restart_fail", {31'd0, bus.fail}, 0);
    chk_val("restart_dfe", {31'd0, bus.dfe_rst_n}, 0);
    m_lfsr = 7'h7F;
    wait_clear();
    train_syms(3, 1'b0, 1'b0);

    // start and abort together: abort wins
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk_val("sa_state", {29'd0, bus.state}, 0);
    chk_val("sa_fail", {31'd0, bus.fail}, 0);
    chk_val("sa_adapt", {31'd0, bus.adapt_en}, 0);

    // Later start reseeds the LFSR
    pulse_start();
    m_lfsr = 7'h7F;
    wait_clear();
    train_syms(16, 1'b1, 1'b0);
    chk_val("track2_state", {29'd0, bus.state}, 3);

    // Reset mid-window discards everything
    bus.sym_valid = 1'b1;
    bus.err = 16'h1000;
    tick(); tick(); tick();
    bus.sym_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_val("mid_rst_state", {29'd0, bus.state}, 0);
    chk_val("mid_rst_adapt", {31'd0, bus.adapt_en}, 0);
    chk_val("mid_rst_dfe", {31'd0, bus.dfe_rst_n}, 1);
    chk_val("mid_rst_tbit", {31'd0, bus.train_bit}, 1);
    chk_val("mid_rst_locked", {31'd0, bus.locked}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dfe_train_ctrl.md
# dfe_train_ctrl

Sequencer for the 2-tap-forward / 2-tap-feedback decision-feedback equalizer. It sits beside the equalizer on the same clock and owns its lifecycle:
- clears the equalizer's delay lines and coefficients;
- runs a training phase against an internal PN7 reference;
- hands over to decision-directed tracking;
- monitors the error signal to declare lock or failure.

## Interface
Parameters:
- TRAIN_LEN, 256: training symbols before handover to tracking (1..65535).
- WIN_LEN, 64: symbols per error-monitoring window (1..255).
- ERR_THR, 16'h2000: an error event is counted when |err| exceeds this value.
- ERR_MAX, 4: maximum error events per window that still count as a good window.
- BAD_MAX, 2: consecutive bad windows in TRACK that force FAIL.
- CLR_CYC, 4: cycles the equalizer is held in clear (1..15).
- PN_SEED, 7'h7F: PN7 load value; must be non-zero.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse that begins a clear/train/track sequence.
- abort  in  1  returns the block to IDLE.
- sym_valid  in  1  a symbol is processed by the equalizer this cycle.
- dec_bit  in  1  equalizer hard decision (1 = -1, 0 = +1).
- err  in  16  signed equalizer error (soft output minus decision).
- dfe_rst_n  out  1  active-low clear to the equalizer.
- adapt_en  out  1  enables coefficient update.
- train_mode  out  1  1 = error reference is train_bit; 0 = reference is dec_bit.
- train_bit  out  1  expected training symbol; same encoding as dec_bit.
- locked  out  1  last complete window was good.
- fail  out  1  sticky failure flag.
- state  out  3  current FSM state code.

## Operation
FSM states (codes): IDLE=0, CLEAR=1, TRAIN=2, TRACK=3, FAIL=4.

- **IDLE**
  - Outputs: dfe_rst_n=1, adapt_en=0, train_mode=0, locked=0.
  - start → CLEAR. fail is cleared on the same transition.
- **CLEAR**
  - dfe_rst_n=0 for exactly CLR_CYC cycles; the PN7 generator is loaded with PN_SEED.
  - → TRAIN when the clear counter expires.
- **TRAIN**
  - Outputs: adapt_en=1, train_mode=1.
  - Each sym_valid increments the training counter and advances the PN7 generator.
  - After the TRAIN_LEN-th sym_valid → TRACK.
  - Errors are not monitored in TRAIN.
- **TRACK**
  - Outputs: adapt_en=1, train_mode=0.
  - Each sym_valid increments the window counter. It also increments the error counter when |err| > ERR_THR.
  - At the WIN_LEN-th symbol, the window closes and that symbol's own error is included. Then both counters reset.
  - Good window (errors ≤ ERR_MAX): locked=1, bad-run counter=0.
  - Bad window: locked=0, bad-run counter increments. When it reaches BAD_MAX → FAIL.
- **FAIL**
  - Outputs: adapt_en=0, locked=0, fail=1, dfe_rst_n=1.
  - start → CLEAR.
- abort in any state → IDLE. Counters are zeroed; fail is preserved.

Arithmetic and event rules:
- |err| is a 16-bit absolute value; -32768 saturates to 32767.
- Error counter saturates at 255.
- PN7 polynomial is x^7+x^6+1.
  - train_bit = lfsr[6].
  - On advance: lfsr <= {lfsr[5:0], lfsr[6]^lfsr[5]}.
  - Period 127; the sequence wraps freely across TRAIN_LEN.
- Simultaneous start and abort: abort wins.
- start in CLEAR, TRAIN or TRACK is ignored.
- sym_valid in IDLE, CLEAR or FAIL is ignored.

## Timing
- All outputs are registered except train_bit, which is driven directly from the lfsr register.
  - train_bit is valid in the same cycle as the sym_valid it labels.
  - The LFSR advances at that clock edge.
- Reset values: state=IDLE, dfe_rst_n=1, adapt_en=0, train_mode=0, locked=0, fail=0, lfsr=PN_SEED.
- Latency from start to dfe_rst_n low: 1 cycle.
- CLEAR lasts CLR_CYC cycles. adapt_en rises on the first TRAIN cycle.
- train_mode falls in the cycle after the TRAIN_LEN-th sym_valid edge.
- locked and fail update in the cycle after the window-closing sym_valid.
- reset asserted mid-operation: all state and outputs return to reset values at the next edge. Any in-progress counts are discarded.
- sym_valid may be asserted back-to-back or sparsely; gaps do not advance any counter.

## Structure
- Package dfe_ctrl_pkg holds:
  - the FSM state enum and its codes;
  - PN7 tap positions;
  - the error-magnitude width constant.
- One sub-module, dfe_pn7_gen, with ports load, seed, adv and bit_out.
- The FSM, counters and error monitor stay in the top module.

## Test plan
- **Reset, then start with CLR_CYC=4:** dfe_rst_n is low for exactly 4 cycles, then adapt_en=1 and train_mode=1.
- **First 8 training symbols with PN_SEED=7F:** train_bit reads 1,1,1,1,1,1,1,0.
- **TRAIN_LEN=16, continuous sym_valid:** train_mode drops after the 16th symbol; locked is still 0.
- **TRACK, WIN_LEN=8, err=16'h1000 on all symbols:** locked=1 after the 8th symbol.
- **Then err=16'h8000 on 5 of 8 symbols for two windows:** locked=0 after the first window; after the second, state=FAIL, fail=1, adapt_en=0.
- **start and abort in the same cycle during TRAIN:** state=IDLE next cycle and fail is unchanged. A later start restarts CLEAR with the LFSR reseeded.
